// File: rtl/accum_xcel_pkg.sv
// Shared types and default widths for the accumulate-accelerator scheduler.
package accum_xcel_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int SIZE_W_DEF = 16;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/accum_xcel_sched_dpath.sv
// Job registers, word address generation, running sum and last-word detect
// for the accumulate-accelerator scheduler.
module accum_xcel_sched_dpath
    import accum_xcel_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SIZE_W = SIZE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic [DATA_W-1:0] o_acc
);

    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << WORD_SHIFT) - 1);

    logic [ADDR_W-1:0] r_base;
    logic [SIZE_W-1:0] r_size;
    logic [SIZE_W-1:0] r_idx;
    logic [DATA_W-1:0] r_acc;
    logic [ADDR_W-1:0] w_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_size <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (i_load) begin
            r_base <= i_base & BASE_MASK;
            r_size <= i_size;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (i_step) begin
            r_idx  <= r_idx + SIZE_W'(1);
            r_acc  <= r_acc + i_data;
        end
    end

    // Offset and sum both wrap silently at their register widths.
    assign w_off  = ADDR_W'({r_idx, {WORD_SHIFT{1'b0}}});
    assign o_addr = r_base + w_off;

    // Compare idx+1 against size one bit wider so a full-range size cannot wrap.
    assign o_last = (({1'b0, r_idx} + (SIZE_W + 1)'(1)) == {1'b0, r_size});
    assign o_acc  = r_acc;

endmodule

// File: rtl/accum_xcel_sched.sv
// Accumulate-accelerator scheduler: accepts a job, streams word reads, returns the sum.
// Optional ACCUM_XCEL_CYCLE_CNT_EN adds a 32-bit saturating busy-cycle counter port.
module accum_xcel_sched
    import accum_xcel_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SIZE_W = SIZE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_val,
    output logic              go_rdy,
    input  logic [ADDR_W-1:0] go_base,
    input  logic [SIZE_W-1:0] go_size,
    output logic              done_val,
    input  logic              done_rdy,
    output logic [DATA_W-1:0] done_result,
    output logic              memreq_val,
    output logic [ADDR_W-1:0] memreq_addr,
    input  logic [DATA_W-1:0] memresp_data,
    output logic              busy
`ifdef ACCUM_XCEL_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    accum_xcel_sched_dpath #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_dpath (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_base (go_base),
        .i_size (go_size),
        .i_data (memresp_data),
        .o_addr (w_addr),
        .o_last (w_last),
        .o_acc  (done_result)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        go_rdy      = 1'b0;
        done_val    = 1'b0;
        memreq_val  = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                go_rdy = 1'b1;
                if (go_val) begin
                    w_load      = 1'b1;
                    w_state_nxt = (go_size != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                memreq_val = 1'b1;
                w_step     = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done_val = 1'b1;
                if (done_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Keep the address port quiet outside CALC.
    assign memreq_addr = (r_state == CALC) ? w_addr : '0;
    assign busy        = (r_state != IDLE);

`ifdef ACCUM_XCEL_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = (r_state == CALC) || ((r_state == DONE) && !done_rdy);

    always_ff @(posedge clk) begin
        if (rst || w_load)                          r_cycle_cnt <= '0;
        else if (w_cnt_inc && (r_cycle_cnt != '1))  r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_accum_xcel_sched.sv
// Directed bench for accum_xcel_sched against a 32-word combinational memory image.
module tb_accum_xcel_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        go_val;
    logic        go_rdy;
    logic [15:0] go_base;
    logic [15:0] go_size;
    logic        done_val;
    logic        done_rdy;
    logic [31:0] done_result;
    logic        memreq_val;
    logic [15:0] memreq_addr;
    logic [31:0] memresp_data;
    logic        busy;
`ifdef ACCUM_XCEL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    int img [32] = '{36, 26, 69, 57, 11, 68, 41, 90,
                     55, 12, 78, 33, 47, 90,  5, 61,
                     28, 74, 39, 50, 83, 17, 66, 22,
                     44, 71,  9, 58, 30, 34, 21,  4};

    always #5 clk = ~clk;

    assign memresp_data = 32'(img[memreq_addr[6:2]]);

    accum_xcel_sched dut (
        .clk          (clk),
        .rst          (rst),
        .go_val       (go_val),
        .go_rdy       (go_rdy),
        .go_base      (go_base),
        .go_size      (go_size),
        .done_val     (done_val),
        .done_rdy     (done_rdy),
        .done_result  (done_result),
        .memreq_val   (memreq_val),
        .memreq_addr  (memreq_addr),
        .memresp_data (memresp_data),
        .busy         (busy)
`ifdef ACCUM_XCEL_CYCLE_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Issue one job, follow every CALC beat, optionally stall the done handshake.
    task automatic do_job(input logic [15:0] base, input logic [15:0] size,
                          input logic [31:0] exp_sum, input int stall);
        logic [15:0] a;
        @(negedge clk);
        chk("go_rdy_idle", go_rdy, 1);
        go_val  = 1'b1;
        go_base = base;
        go_size = size;
        @(posedge clk);
        #1 go_val = 1'b0;
        for (int k = 0; k < int'(size); k++) begin
            @(negedge clk);
            a = (base & 16'hFFFC) + 16'(k * 4);
            chk("memreq_val_calc", memreq_val, 1);
            chk("memreq_addr", memreq_addr, a);
            chk("go_rdy_calc", go_rdy, 0);
        end
        @(negedge clk);
        chk("done_val", done_val, 1);
        chk("done_result", done_result, exp_sum);
        chk("memreq_val_done", memreq_val, 0);
        chk("memreq_addr_done", memreq_addr, 0);
        chk("busy_done", busy, 1);
`ifdef ACCUM_XCEL_CYCLE_CNT_EN
        chk("cycle_cnt_calc", cycle_cnt, 32'(size));
`endif
        for (int s = 0; s < stall; s++) begin
            if (s == 0) begin
                go_val  = 1'b1;
                go_base = 16'h0040;
                go_size = 16'd3;
            end
            @(negedge clk);
            chk("stall_done_val", done_val, 1);
            chk("stall_result", done_result, exp_sum);
            chk("stall_go_rdy", go_rdy, 0);
        end
        go_val   = 1'b0;
        done_rdy = 1'b1;
        @(posedge clk);
        #1 done_rdy = 1'b0;
        @(negedge clk);
        chk("post_go_rdy", go_rdy, 1);
        chk("post_done_val", done_val, 0);
        chk("post_busy", busy, 0);
        chk("post_memreq_val", memreq_val, 0);
        chk("post_result_kept", done_result, exp_sum);
`ifdef ACCUM_XCEL_CYCLE_CNT_EN
        chk("cycle_cnt_frozen", cycle_cnt, 32'(size) + 32'(stall));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        go_val   = 1'b0;
        go_base  = '0;
        go_size  = '0;
        done_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_go_rdy", go_rdy, 1);
        chk("rst_done_val", done_val, 0);
        chk("rst_done_result", done_result, 0);
        chk("rst_memreq_val", memreq_val, 0);
        chk("rst_memreq_addr", memreq_addr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        do_job(16'h0000, 16'd8,  32'd398,  0);
        do_job(16'h0000, 16'd32, 32'd1429, 0);
        do_job(16'h0010, 16'd3,  32'd120,  0);
        do_job(16'h0013, 16'd1,  32'd11,   0);
        do_job(16'h0000, 16'd0,  32'd0,    0);
        do_job(16'h0000, 16'd8,  32'd398,  5);

        // Abandon a job mid-stream with reset.
        @(negedge clk);
        go_val  = 1'b1;
        go_base = 16'h0000;
        go_size = 16'd8;
        @(posedge clk);
        #1 go_val = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_go_rdy", go_rdy, 1);
        chk("midrst_memreq_val", memreq_val, 0);
        chk("midrst_done_val", done_val, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", done_result, 0);
        rst = 1'b0;
        do_job(16'h0000, 16'd2, 32'd62, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/accum_xcel_sched.md
Name: accum_xcel_sched

Overview:
- Control/sequencing unit for the accumulate accelerator.
- Accepts a job (base byte address, word count) over a val/rdy handshake.
- Drives the word-addressed, combinational-read accelerator memory port with one request per cycle and sums the returned words.
- Returns the 32-bit sum over a val/rdy handshake. Sits between the processor's accelerator interface and the accelerator memory.

Parameters:
- ADDR_W, 16, memory request byte-address width.
- DATA_W, 32, memory data and accumulator width.
- SIZE_W, 16, job word-count width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- go_val  input  1  job request valid.
- go_rdy  output  1  block can accept a job.
- go_base  input  ADDR_W  job base byte address; bits [1:0] ignored.
- go_size  input  SIZE_W  number of 32-bit words to sum.
- done_val  output  1  result valid.
- done_rdy  input  1  consumer accepts result.
- done_result  output  DATA_W  accumulated sum.
- memreq_val  output  1  memory read request.
- memreq_addr  output  ADDR_W  request byte address; bits [1:0] always 0.
- memresp_data  input  DATA_W  read data, valid combinationally in the same cycle as memreq_val.
- busy  output  1  high in CALC or DONE.

Behaviour:
- FSM states: IDLE, CALC, DONE. Registers: state, base, size, idx (SIZE_W), acc (DATA_W).
- Reset: state=IDLE, idx=0, acc=0, base=0, size=0.
  - Outputs after reset: go_rdy=1, done_val=0, done_result=0, memreq_val=0, memreq_addr=0, busy=0.
- IDLE:
  - go_rdy=1.
  - On go_val, latch base={go_base[ADDR_W-1:2],2'b00}, size=go_size; clear idx and acc.
  - Next state is CALC if go_size!=0, else DONE (result 0).
- CALC:
  - memreq_val=1, memreq_addr=base+(idx<<2), computed modulo 2^ADDR_W (address wraps silently).
  - Each cycle: acc<=acc+memresp_data (wraps modulo 2^DATA_W), idx<=idx+1.
  - When idx==size-1, the last word is added and the next state is DONE.
  - go_rdy=0.
- DONE:
  - done_val=1, done_result=acc; held stable until handshake.
  - On done_rdy, go to IDLE. Acc is retained so done_result stays readable, but done_val drops.
- memreq_val is 0 outside CALC. memreq_addr is 0 outside CALC (no X on the port).
- Latency: go accepted at cycle T gives CALC cycles T+1..T+N and done_val at T+N+1. For N=0, done_val is at T+1.
- No new job is accepted in CALC or DONE; go_val there is ignored and not queued.
- The done handshake and a new go_val cannot overlap: go_rdy only rises in the cycle after the done handshake.
- Maximum size is 2^SIZE_W-1 words. The idx compare must not overflow.
- rst asserted mid-job: the job is abandoned, the FSM returns to IDLE with all registers cleared next cycle, and no result is produced.

Optional Feature:
- Macro ACCUM_XCEL_CYCLE_CNT_EN.
- Defined:
  - Adds output port cycle_cnt, 32 bits.
  - Cleared on rst and on go acceptance; increments every cycle in CALC or DONE with done_val && !done_rdy.
  - Freezes at the done handshake and saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package accum_xcel_pkg:
  - state enum (IDLE/CALC/DONE, 2-bit);
  - constants ADDR_W/DATA_W/SIZE_W defaults;
  - WORD_SHIFT=2.
- One sub-module, accum_xcel_sched_dpath: base/size/idx/acc registers, address adder, idx==size-1 compare. The FSM stays in the top-level module.

Test Plan:
- Memory preloaded with the standard 32-word test image (36,26,69,57,11,68,41,90,...,21,4).
  - go base=0x0000 size=8 -> memreq_addr 0x00..0x1C on consecutive cycles; done_val at T+9; done_result=398.
- go base=0x0000 size=32 -> done_result=1429 at T+33.
- go base=0x0010 size=3 -> addresses 0x10,0x14,0x18; done_result=120.
- go base=0x0013 (low bits ignored) size=1 -> address 0x10; done_result=11.
- go size=0 -> no memreq_val pulses; done_val at T+1, done_result=0.
- done_rdy held low 5 cycles after done_val:
  - done_result stays 398 and go_rdy stays 0;
  - a go_val during the stall is ignored;
  - on done_rdy=1, the FSM returns to IDLE.
- rst asserted at T+4 of a size=8 job -> next cycle IDLE, go_rdy=1, memreq_val=0, done_val=0. A fresh size=2 job then gives 62.
